// File: rtl/cam_pkg.sv
// Shared constants and FSM encoding for the camera frame-capture sequencer.
package cam_pkg;

    localparam int H_PIX     = 160;
    localparam int V_LINES   = 120;
    localparam int FRAME_PIX = H_PIX * V_LINES;
    localparam int ADDR_W    = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_SYNC,
        ST_CAPT,
        ST_END
    } state_t;

endpackage

// File: rtl/cam_frame_ctrl_if.sv
// Pixel-in / frame-RAM-out bus of the capture sequencer.
interface cam_frame_ctrl_if
    import cam_pkg::*;
#(
    parameter int AW = ADDR_W
);
    logic          px_we_in;
    logic [7:0]    px_data_in;
    logic          ram_we;
    logic [AW:0]   ram_addr;
    logic [7:0]    ram_data;

    modport master (
        output px_we_in, px_data_in,
        input  ram_we, ram_addr, ram_data
    );

    modport slave (
        input  px_we_in, px_data_in,
        output ram_we, ram_addr, ram_data
    );
endinterface

// File: rtl/cam_sync_edge.sv
// Registers VSync/Href once and derives the frame and line edge strobes.
module cam_sync_edge (
    input  logic Pclk,
    input  logic rst,
    input  logic i_vsync,
    input  logic i_href,
    output logic o_vs_rise,
    output logic o_vs_fall,
    output logic o_hr_rise
);
    logic r_vs_q;
    logic r_hr_q;

    always_ff @(posedge Pclk) begin
        if (rst) begin
            r_vs_q <= 1'b0;
            r_hr_q <= 1'b0;
        end else begin
            r_vs_q <= i_vsync;
            r_hr_q <= i_href;
        end
    end

    assign o_vs_rise = i_vsync & ~r_vs_q;
    assign o_vs_fall = ~i_vsync & r_vs_q;
    assign o_hr_rise = i_href & ~r_hr_q;
endmodule

// File: rtl/cam_frame_ctrl.sv
// Frame-capture sequencer: aligns to VSync, writes one double-buffered bank,
// and hands the bank to the display only after a complete, well-formed frame.
module cam_frame_ctrl #(
    parameter int H_PIX   = cam_pkg::H_PIX,
    parameter int V_LINES = cam_pkg::V_LINES,
    parameter int ADDR_W  = cam_pkg::ADDR_W
) (
    input  logic                Pclk,
    input  logic                rst,
    input  logic                start,
    input  logic                cont,
    input  logic                VSync,
    input  logic                Href,
    cam_frame_ctrl_if.slave     bus,
    output logic                disp_bank,
    output logic                busy,
    output logic                frame_done,
    output logic                frame_err
);
    import cam_pkg::*;

    localparam int PW = $clog2(H_PIX + 1);
    localparam int LW = $clog2(V_LINES + 2);
    localparam logic [ADDR_W:0] C_FRAME = (ADDR_W + 1)'(H_PIX * V_LINES);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_wr_bank;
    logic                r_disp_bank;
    logic [ADDR_W:0]     r_wr_addr;
    logic [PW-1:0]       r_pix_in_line;
    logic [LW-1:0]       r_line_cnt;
    logic                r_err;
    logic                r_ram_we;
    logic [ADDR_W:0]     r_ram_addr;
    logic [7:0]          r_ram_data;
    logic                r_frame_done;
    logic                r_frame_err;

    logic                w_vs_rise;
    logic                w_vs_fall;
    logic                w_hr_rise;
    logic [PW-1:0]       w_pix_eff;
    logic [LW-1:0]       w_line_eff;
    logic                w_strobe;
    logic                w_accept;
    logic                w_good;

    function automatic logic [LW-1:0] sat_inc(input logic [LW-1:0] v);
        return (&v) ? v : v + LW'(1);
    endfunction

    cam_sync_edge u_edge (
        .Pclk      (Pclk),
        .rst       (rst),
        .i_vsync   (VSync),
        .i_href    (Href),
        .o_vs_rise (w_vs_rise),
        .o_vs_fall (w_vs_fall),
        .o_hr_rise (w_hr_rise)
    );

    // A strobe coinciding with the line start belongs to the new line.
    assign w_pix_eff  = w_hr_rise ? '0 : r_pix_in_line;
    assign w_line_eff = w_hr_rise ? sat_inc(r_line_cnt) : r_line_cnt;
    assign w_strobe   = (r_state == ST_CAPT) & bus.px_we_in & Href & ~VSync;
    assign w_accept   = w_strobe & (w_pix_eff < PW'(H_PIX))
                      & (w_line_eff <= LW'(V_LINES)) & (r_wr_addr < C_FRAME);
    assign w_good     = (r_wr_addr == C_FRAME) & (r_line_cnt == LW'(V_LINES)) & ~r_err;

    always_ff @(posedge Pclk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start || cont) w_state_nxt = ST_ARM;
            ST_ARM:  if (VSync)         w_state_nxt = ST_SYNC;
            ST_SYNC: if (w_vs_fall)     w_state_nxt = ST_CAPT;
            ST_CAPT: if (w_vs_rise)     w_state_nxt = ST_END;
            ST_END:  w_state_nxt = cont ? ST_SYNC : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Pclk) begin
        if (rst) begin
            r_wr_bank     <= 1'b0;
            r_disp_bank   <= 1'b1;
            r_wr_addr     <= '0;
            r_pix_in_line <= '0;
            r_line_cnt    <= '0;
            r_err         <= 1'b0;
            r_ram_we      <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_data    <= '0;
            r_frame_done  <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_ram_we     <= w_accept;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            if (w_accept) begin
                r_ram_addr <= {r_wr_bank, r_wr_addr[ADDR_W-1:0]};
                r_ram_data <= bus.px_data_in;
            end
            case (r_state)
                ST_SYNC: begin
                    if (w_vs_fall) begin
                        r_wr_addr     <= '0;
                        r_pix_in_line <= '0;
                        r_line_cnt    <= '0;
                        r_err         <= 1'b0;
                    end
                end
                ST_CAPT: begin
                    r_line_cnt    <= w_line_eff;
                    r_pix_in_line <= w_pix_eff + PW'(w_accept);
                    if (w_accept)             r_wr_addr <= r_wr_addr + (ADDR_W + 1)'(1);
                    if (w_strobe && !w_accept) r_err    <= 1'b1;
                end
                ST_END: begin
                    // Failed frames keep the bank so the next frame overwrites it.
                    if (w_good) begin
                        r_frame_done <= 1'b1;
                        r_disp_bank  <= r_wr_bank;
                        r_wr_bank    <= ~r_wr_bank;
                    end else begin
                        r_frame_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ram_we   = r_ram_we;
    assign bus.ram_addr = r_ram_addr;
    assign bus.ram_data = r_ram_data;
    assign disp_bank    = r_disp_bank;
    assign busy         = (r_state != ST_IDLE);
    assign frame_done   = r_frame_done;
    assign frame_err    = r_frame_err;
endmodule
